// File: rtl/veggie_pkg.sv
// Shared constants and enums for the frame buffer write path.
// The NIOS handshake codes and the fill-engine FSM states live here.
package veggie_pkg;

    localparam int unsigned H_RES   = 640;
    localparam int unsigned V_RES   = 480;
    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned COLOR_W = 8;

    typedef enum logic [1:0] {
        OP_FILL  = 2'b00,
        OP_CLEAR = 2'b01,
        OP_RSVD2 = 2'b10,
        OP_RSVD3 = 2'b11
    } draw_op_t;

    typedef enum logic [1:0] {
        HS_IDLE = 2'b00,
        HS_BUSY = 2'b01,
        HS_DONE = 2'b10
    } hs_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SETUP = 2'b01,
        ST_DRAW  = 2'b10,
        ST_DONE  = 2'b11
    } fw_state_t;

endpackage

// File: rtl/frame_writer_if.sv
// Command/status words from the NIOS PIOs plus the frame buffer write port.
// Handshake: software raises to_hw_sig=01 with the cmd_* words stable; hardware
// answers 01 (busy) then 10 (done); software drops to 00 and hardware returns to 00.
interface frame_writer_if;
    import veggie_pkg::*;

    logic [1:0]         to_hw_sig;
    logic [31:0]        cmd_pos;
    logic [31:0]        cmd_size;
    logic [31:0]        cmd_color;
    logic [1:0]         to_sw_sig;
    logic [ADDR_W-1:0]  frame_wrAddress;
    logic [COLOR_W-1:0] frame_input;
    logic               frame_we;

    modport master (
        output to_hw_sig, cmd_pos, cmd_size, cmd_color,
        input  to_sw_sig, frame_wrAddress, frame_input, frame_we
    );

    modport slave (
        input  to_hw_sig, cmd_pos, cmd_size, cmd_color,
        output to_sw_sig, frame_wrAddress, frame_input, frame_we
    );

endinterface

// File: rtl/rect_clip.sv
// Combinational clip of a fill rectangle against the visible frame; also
// produces the first-pixel address without a multiplier.
module rect_clip
    import veggie_pkg::*;
(
    input  draw_op_t          op,
    input  logic [9:0]        x0,
    input  logic [9:0]        y0,
    input  logic [9:0]        w,
    input  logic [9:0]        h,
    output logic [9:0]        w_eff,
    output logic [9:0]        h_eff,
    output logic              empty,
    output logic [ADDR_W-1:0] base_addr
);

    logic [9:0]  x_s, y_s, w_s, h_s;
    logic [10:0] rem_w, rem_h;
    logic        x_out, y_out;

    always_comb begin
        x_s = x0;
        y_s = y0;
        w_s = w;
        h_s = h;
        if (op == OP_CLEAR) begin
            x_s = '0;
            y_s = '0;
            w_s = 10'(H_RES);
            h_s = 10'(V_RES);
        end

        x_out = ({1'b0, x_s} >= 11'(H_RES));
        y_out = ({1'b0, y_s} >= 11'(V_RES));
        // Remaining span wraps when the origin is off-screen; empty covers that case.
        rem_w = 11'(H_RES) - {1'b0, x_s};
        rem_h = 11'(V_RES) - {1'b0, y_s};
        w_eff = ({1'b0, w_s} < rem_w) ? w_s : rem_w[9:0];
        h_eff = ({1'b0, h_s} < rem_h) ? h_s : rem_h[9:0];

        empty = (op == OP_RSVD2) || (op == OP_RSVD3) || x_out || y_out ||
                (w_eff == 10'd0) || (h_eff == 10'd0);

        // y*640 = y*512 + y*128
        base_addr = (ADDR_W'(y_s) << 9) + (ADDR_W'(y_s) << 7) + ADDR_W'(x_s);
    end

endmodule

// File: rtl/frame_writer.sv
// Rectangle-fill / clear engine: one pixel per clock into the frame buffer
// write port, driven by the NIOS four-phase request/status handshake.
module frame_writer
    import veggie_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    frame_writer_if.slave     bus,
    output fw_state_t         dbg_state
);

    fw_state_t          state_q, state_d;
    logic [9:0]         col_q, col_d, row_q, row_d, w_q, w_d, h_q, h_d;
    logic [ADDR_W-1:0]  base_q, base_d, addr_q, addr_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               we_q, we_d;
    hs_code_t           sw_q, sw_d;

    draw_op_t           clip_op;
    logic [9:0]         clip_w, clip_h;
    logic               clip_empty;
    logic [ADDR_W-1:0]  clip_base;
    logic               unused_bits;

    assign clip_op     = draw_op_t'(bus.cmd_color[9:8]);
    assign unused_bits = ^{bus.cmd_pos[31:26], bus.cmd_pos[15:10],
                           bus.cmd_size[31:26], bus.cmd_size[15:10],
                           bus.cmd_color[31:10]};

    rect_clip u_clip (
        .op        (clip_op),
        .x0        (bus.cmd_pos[9:0]),
        .y0        (bus.cmd_pos[25:16]),
        .w         (bus.cmd_size[9:0]),
        .h         (bus.cmd_size[25:16]),
        .w_eff     (clip_w),
        .h_eff     (clip_h),
        .empty     (clip_empty),
        .base_addr (clip_base)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        w_d     = w_q;
        h_d     = h_q;
        base_d  = base_q;
        addr_d  = addr_q;
        color_d = color_q;
        we_d    = 1'b0;
        sw_d    = HS_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (bus.to_hw_sig == 2'b01) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                w_d     = clip_w;
                h_d     = clip_h;
                base_d  = clip_base;
                addr_d  = clip_base;
                col_d   = '0;
                row_d   = '0;
                color_d = bus.cmd_color[COLOR_W-1:0];
                if (clip_empty) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAW;
                    we_d    = 1'b1;
                end
            end
            ST_DRAW: begin
                // col_q/row_q index the pixel currently on the write port.
                if (col_q == w_q - 10'd1) begin
                    if (row_q == h_q - 10'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        col_d  = '0;
                        row_d  = row_q + 10'd1;
                        base_d = base_q + ADDR_W'(H_RES);
                        addr_d = base_q + ADDR_W'(H_RES);
                        we_d   = 1'b1;
                    end
                end else begin
                    col_d  = col_q + 10'd1;
                    addr_d = addr_q + ADDR_W'(1);
                    we_d   = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.to_hw_sig == 2'b00) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_IDLE: sw_d = HS_IDLE;
            ST_DONE: sw_d = HS_DONE;
            default: sw_d = HS_BUSY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            w_q     <= '0;
            h_q     <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            color_q <= '0;
            we_q    <= 1'b0;
            sw_q    <= HS_IDLE;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            w_q     <= w_d;
            h_q     <= h_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            color_q <= color_d;
            we_q    <= we_d;
            sw_q    <= sw_d;
        end
    end

    assign bus.to_sw_sig       = sw_q;
    assign bus.frame_wrAddress = addr_q;
    assign bus.frame_input     = color_q;
    assign bus.frame_we        = we_q;
    assign dbg_state           = state_q;

endmodule

// File: doc/frame_writer.md
# frame_writer

Pixel-fill engine on the write side of the 640x480x8 frame buffer. It takes rectangle-fill and clear-screen commands from the NIOS through the two-bit `to_hw_sig` / `to_sw_sig` handshake and the `to_hw_port*` PIO words. It writes one pixel per clock into the frame buffer's write port, which `frame_displayer` reads out independently on the read port. It sits between `hardware_software_comm` and `Frame_Buffer` and owns `frame_wrAddress`, `frame_input` and `frame_we`.

## Interface
- `H_RES`, 640, visible width in pixels.
- `V_RES`, 480, visible height in pixels.
- `ADDR_W`, 19, frame buffer address width.
- `COLOR_W`, 8, pixel width.

One clock; reset is synchronous and active-low.

- `Clk` in 1: system clock, CLOCK_50.
- `Reset_n` in 1: synchronous, active-low reset.
- `to_hw_sig` in 2: request from software; 01 = request, 00 = release.
- `cmd_pos` in 32: x0 in [9:0], y0 in [25:16]; connected to `to_hw_port1`.
- `cmd_size` in 32: w in [9:0], h in [25:16]; connected to `to_hw_port2`.
- `cmd_color` in 32: color in [7:0], opcode in [9:8]; connected to `to_hw_port3`.
- `to_sw_sig` out 2: status to software; 00 idle, 01 busy, 10 done.
- `frame_wrAddress` out ADDR_W: write address, y*640+x.
- `frame_input` out COLOR_W: write data.
- `frame_we` out 1: write enable, one pixel per asserted cycle.

## Operation
Opcodes:
- 00 FILL: fill a rectangle with the command color.
- 01 CLEAR: whole frame, x0=y0=0, w=640, h=480; `cmd_pos` and `cmd_size` are ignored.
- 10, 11: no-op, zero pixels.

States: IDLE, SETUP, DRAW, DONE.
- **IDLE:** when `to_hw_sig`==01, go to SETUP. Other `to_hw_sig` codes are ignored.
- **SETUP:** latch all command fields; software may rewrite the ports afterwards.
  - Clip in 11-bit arithmetic: `w_eff` = min(w, H_RES−x0) and `h_eff` = min(h, V_RES−y0).
  - If x0≥H_RES, y0≥V_RES, `w_eff`=0 or `h_eff`=0, the command is empty.
  - Compute the row base as (y0<<9)+(y0<<7)+x0. No multiplier.
  - Empty command goes to DONE; otherwise go to DRAW.
- **DRAW:** assert `frame_we` with the current address and color.
  - Increment the column counter each cycle.
  - At the last column, reset the column counter and add 640 to the row base.
  - After pixel `w_eff*h_eff`, go to DONE.
  - Changes on `to_hw_sig` during DRAW are ignored; a draw always completes.
- **DONE:** hold `to_sw_sig`=10 until `to_hw_sig`==00, then go to IDLE. This is a four-phase handshake.

`to_sw_sig` by state: 00 in IDLE, 01 in SETUP and DRAW, 10 in DONE.

Address arithmetic:
- Addresses never exceed 307199 because of clipping.
- No wrap-around is possible.
- Counters are 10 bits; the row base is ADDR_W bits.

## Timing
Reset (`Reset_n`=0 at an edge):
- State goes to IDLE.
- `frame_we`=0, `frame_wrAddress`=0, `frame_input`=0, `to_sw_sig`=00.
- Reset during DRAW aborts the command. No write occurs in the cycle after reset.
- If `to_hw_sig` is still 01 after reset releases, a new command starts.

All outputs are registered. Cycle numbers are counted from the edge that samples the request in IDLE (cycle 0):
- Cycle 1: SETUP, `to_sw_sig`=01.
- Cycles 2 … 1+N: `frame_we`=1, with N = `w_eff*h_eff`.
- Cycle 2+N: `to_sw_sig`=10, `frame_we`=0.
- Empty command: `to_sw_sig`=10 at cycle 2 with no writes.
- Release: the first edge seeing `to_hw_sig`==00 in DONE gives `to_sw_sig`=00 on the next cycle.
- A new request is accepted no earlier than the cycle after the return to IDLE.

Throughput: one pixel per clock. A full clear takes 307200 cycles plus 3 cycles of overhead.

## Structure
- Package `veggie_pkg` holds:
  - `H_RES`, `V_RES`, `ADDR_W`, `COLOR_W`.
  - enum `draw_op_t` {OP_FILL, OP_CLEAR, OP_RSVD2, OP_RSVD3}.
  - enum `hs_code_t` {HS_IDLE=00, HS_BUSY=01, HS_DONE=10}.
  - the state enum.
- One natural sub-module: `rect_clip`. It is combinational and takes x0, y0, w, h and the opcode, and produces `w_eff`, `h_eff`, empty and `base_addr`. The SETUP register captures its outputs.
- The FSM and counters live in `frame_writer`.

## Test plan
1. **Reset:** `Reset_n` low for 2 cycles with `to_hw_sig`=00 → all outputs 0 and `to_sw_sig`=00.
2. **Basic fill:** FILL x0=10, y0=2, w=3, h=2, color 0x1C →
   - 6 writes at 1290, 1291, 1292, 1930, 1931, 1932 on cycles 2–7, all with data 0x1C;
   - `to_sw_sig`=10 at cycle 8;
   - `to_sw_sig`=00 one cycle after `to_hw_sig` drops to 00.
3. **Clipping:** FILL x0=638, y0=479, w=5, h=5 → exactly 2 writes, at 307198 and 307199, then done.
4. **Empty commands:** FILL w=0, h=7; FILL x0=700; opcode 10 → each gives no `frame_we` pulses and `to_sw_sig`=10 at cycle 2.
5. **Clear screen:** CLEAR with color 0xFF and garbage in `cmd_pos`/`cmd_size` → 307200 consecutive writes at addresses 0…307199, then done.
6. **Reset mid-draw:** FILL 100x100; assert `Reset_n`=0 at write 50 → `frame_we`=0 from the next cycle; no further writes while `to_hw_sig`=00; `to_sw_sig`=00.
